img_frame_capture: RTL

- Upstream stage of the image readout path. Captures exactly one full frame from the parallel image-sensor port (img_d/img_fv/img_lv) per trigger.
- Zero-extends each 12-bit pixel to a 16-bit word and buffers it in a small FIFO. Presents the words on a valid/ready stream to the RAM-writer / readout-to-SD stage.
- Reports frame geometry, pixel count and overflow status.
- The sensor cannot be stalled, so backpressure is absorbed by the FIFO. Pixels that arrive while the FIFO is full are dropped and flagged.

---
 rtl/img_capture_pkg.sv | 31 +++
 rtl/img_pixel_fifo.sv | 59 +++++
 rtl/img_frame_capture.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/img_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : img_capture_pkg
//  Purpose  : Shared widths, FSM state encoding and helpers for the
//             image-sensor frame capture block.
//  Revision : 1.0 - initial release
// ============================================================================
package img_capture_pkg;

  localparam int PixelWidth     = 12;
  localparam int WordWidth      = 16;
  localparam int LineCountWidth = 12;

  // Capture FSM encoding: fixed 3-bit codes so waveforms and external
  // status decoders see stable values.
  localparam int StateWidth = 3;
  typedef logic [StateWidth-1:0] capture_state_t;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WAIT_FV_LOW  = 3'd1;
  localparam logic [2:0] ST_WAIT_FV_HIGH = 3'd2;
  localparam logic [2:0] ST_CAPTURE      = 3'd3;
  localparam logic [2:0] ST_DONE         = 3'd4;

  // A sensor pixel travels downstream zero-extended to the stream word width.
  function automatic logic [WordWidth-1:0] pixel_to_word(input logic [PixelWidth-1:0] pix);
    return {{(WordWidth-PixelWidth){1'b0}}, pix};
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : img_pixel_fifo
//  Purpose  : Single-clock FIFO absorbing downstream backpressure for the
//             pixel stream. Depth must be a power of two (>= 4).
//             Pointers carry one extra wrap bit to tell full from empty.
//  Revision : 1.0 - initial release
// ============================================================================
module img_pixel_fifo
  import img_capture_pkg::*;
#(
  parameter int Depth = 16,
  parameter int Width = WordWidth
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty
);

  localparam int AddrWidth = $clog2(Depth);

  logic [Width-1:0]   mem [Depth];
  logic [AddrWidth:0] wr_ptr;
  logic [AddrWidth:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Full is judged on the registered pointers only, so a pop in the same
  // cycle never creates room for a push.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                    (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AddrWidth-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AddrWidth+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AddrWidth+1)'(1);
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AddrWidth-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/img_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module   : img_frame_capture
//  Purpose  : Captures one full sensor frame per trigger, zero-extends each
//             12-bit pixel to 16 bits and streams it out through a FIFO.
//             Reports pixel/line counts, first-line width and overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module img_frame_capture
  import img_capture_pkg::*;
#(
  parameter int FifoDepth  = 16,
  parameter int MaxPixels  = 2304*1296,
  parameter int CountWidth = 22
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      trigger,
  input  logic [PixelWidth-1:0]     img_d,
  input  logic                      img_fv,
  input  logic                      img_lv,
  output logic                      pix_valid,
  output logic [WordWidth-1:0]      pix_data,
  input  logic                      pix_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [CountWidth-1:0]     pixel_count,
  output logic [LineCountWidth-1:0] line_count,
  output logic [LineCountWidth-1:0] line_width
);

  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxPixels);

  // Sensor inputs after one register stage, plus the previous S1 values.
  logic [PixelWidth-1:0] s1_d;
  logic                  s1_fv;
  logic                  s1_lv;
  logic                  s2_fv;
  logic                  s2_lv;

  capture_state_t state;
  capture_state_t state_nxt;

  logic fv_rise;
  logic fv_fall;
  logic lv_fall;
  logic start;
  logic in_frame;
  logic is_pixel;
  logic below_max;
  logic line_end;

  logic                      fifo_push;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [WordWidth-1:0]      fifo_head;
  logic                      pix_drop;
  logic [LineCountWidth-1:0] line_pix;
  logic                      first_line_done;

  // Register sensor pins once and keep a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s1_d  <= '0;
      s1_fv <= 1'b0;
      s1_lv <= 1'b0;
      s2_fv <= 1'b0;
      s2_lv <= 1'b0;
    end else begin
      s1_d  <= img_d;
      s1_fv <= img_fv;
      s1_lv <= img_lv;
      s2_fv <= s1_fv;
      s2_lv <= s1_lv;
    end
  end

  assign fv_rise = s1_fv && !s2_fv;
  assign fv_fall = !s1_fv && s2_fv;
  assign lv_fall = !s1_lv && s2_lv;
  assign start   = (state == ST_IDLE) && trigger;

  // The cycle of the fv rising edge already belongs to the frame, so a
  // pixel that coincides with it is not lost.
  assign in_frame  = (state == ST_CAPTURE) ||
                     ((state == ST_WAIT_FV_HIGH) && fv_rise);
  assign is_pixel  = in_frame && s1_fv && s1_lv;
  assign below_max = (pixel_count < MaxCount);
  assign fifo_push = is_pixel && below_max && !fifo_full;
  assign pix_drop  = is_pixel && below_max && fifo_full;
  // s2_fv rather than s1_fv: a line ending together with the frame counts.
  assign line_end  = in_frame && lv_fall && s2_fv;

  // Next-state logic of the capture sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (trigger) state_nxt = ST_WAIT_FV_LOW;
      ST_WAIT_FV_LOW:  if (!s1_fv)  state_nxt = ST_WAIT_FV_HIGH;
      ST_WAIT_FV_HIGH: if (fv_rise) state_nxt = ST_CAPTURE;
      ST_CAPTURE:      if (fv_fall) state_nxt = ST_DONE;
      ST_DONE:                      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Frame statistics: cleared on an accepted trigger, saturating otherwise.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pixel_count     <= '0;
      line_count      <= '0;
      line_width      <= '0;
      line_pix        <= '0;
      first_line_done <= 1'b0;
      overflow        <= 1'b0;
    end else if (start) begin
      pixel_count     <= '0;
      line_count      <= '0;
      line_width      <= '0;
      line_pix        <= '0;
      first_line_done <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (fifo_push) pixel_count <= pixel_count + CountWidth'(1);
      if (pix_drop)  overflow    <= 1'b1;
      if (line_end) begin
        if (line_count != '1) line_count <= line_count + LineCountWidth'(1);
        if (!first_line_done) begin
          line_width      <= line_pix;
          first_line_done <= 1'b1;
        end
        line_pix <= '0;
      end else if (is_pixel && (line_pix != '1)) begin
        line_pix <= line_pix + LineCountWidth'(1);
      end
    end
  end

  img_pixel_fifo #(
    .Depth (FifoDepth),
    .Width (WordWidth)
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (fifo_push),
    .push_data (pixel_to_word(s1_d)),
    .full      (fifo_full),
    .pop       (pix_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty)
  );

  // Stream is the FIFO head; data is forced to zero while nothing is held.
  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_empty ? '0 : fifo_head;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule
`default_nettype wire
